// File: rtl/iic_pkg.sv
// Shared types and constants for the 16-bit-address / 8-bit-data I2C master.
package iic_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StStart,
      StDevW,
      StAddrH,
      StAddrL,
      StWdata,
      StRstart,
      StDevR,
      StRdata,
      StStop
   } iic_state_t;

   localparam logic W_BIT = 1'b0;
   localparam logic R_BIT = 1'b1;

   function automatic int unsigned div_width(input int unsigned div);
      return (div < 2) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/iic_tick_gen.sv
// Quarter-SCL tick generator: one-cycle pulse every DIV clocks while enabled, cleared when not.
module iic_tick_gen
   import iic_pkg::*;
#(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic rstn,
   input  logic i_en,
   output logic o_tick
);

   localparam int unsigned CW = div_width(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
      end else if (!i_en || (r_cnt == LAST)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/iic_master_a16d8.sv
// I2C master: single-register write or random read with 8-bit device ID, 16-bit address and
// 8-bit data over an open-drain SCL/SDA pair.
module iic_master_a16d8
   import iic_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned IIC_FREQ = 100_000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [7:0]  device_id,
   input  logic        iic_trig,
   input  logic        w_r,
   input  logic [15:0] addr,
   input  logic [7:0]  data_in,
   output logic        busy,
   output logic [7:0]  data_out,
   output logic        byte_over,
   output logic        ack_err,
   output logic        scl,
   output logic        sda_oe,
   input  logic        sda_in
);

   localparam int unsigned DIV = CLK_FREQ / (4 * IIC_FREQ);

   iic_state_t  r_state, w_state_d;
   logic [1:0]  r_q, w_q_d;
   logic [2:0]  r_bit, w_bit_d;
   logic        r_ack, w_ack_d;
   logic [7:0]  r_shift, w_shift_d;
   logic [6:0]  r_dev, w_dev_d;
   logic        r_wr, w_wr_d;
   logic [15:0] r_addr, w_addr_d;
   logic [7:0]  r_wdata, w_wdata_d;
   logic [7:0]  r_data_out, w_data_out_d;
   logic        r_ack_err, w_ack_err_d;
   logic        r_byte_over, w_byte_over_d;
   logic        r_busy, r_scl, r_sda_oe;
   logic [1:0]  w_drive;
   logic        w_tick, w_tx_state, w_unused;

   // {scl, sda_oe} for the current quarter of each state.
   function automatic logic [1:0] bus_drive(input iic_state_t st, input logic [1:0] q,
                                            input logic ack, input logic txb);
      logic mid;
      mid = (q == 2'd1) || (q == 2'd2);
      case (st)
         StIdle:   return 2'b10;
         StStart:  return {q != 2'd3, q[1]};
         StRstart: return {mid, q[1]};
         StStop:   return {q != 2'd0, ~q[1]};
         StRdata:  return {mid, 1'b0};
         default:  return {mid, ~ack & ~txb};
      endcase
   endfunction

   iic_tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .clk    (clk),
      .rstn   (rstn),
      .i_en   (r_state != StIdle),
      .o_tick (w_tick)
   );

   assign w_tx_state = (r_state == StDevW) || (r_state == StAddrH) || (r_state == StAddrL) ||
                       (r_state == StWdata) || (r_state == StDevR);
   assign w_unused   = device_id[0];
   assign w_drive    = bus_drive(r_state, r_q, r_ack, r_shift[7]);

   always_comb begin
      w_state_d     = r_state;
      w_q_d         = r_q;
      w_bit_d       = r_bit;
      w_ack_d       = r_ack;
      w_shift_d     = r_shift;
      w_dev_d       = r_dev;
      w_wr_d        = r_wr;
      w_addr_d      = r_addr;
      w_wdata_d     = r_wdata;
      w_data_out_d  = r_data_out;
      w_ack_err_d   = r_ack_err;
      w_byte_over_d = 1'b0;
      if (r_state == StIdle) begin
         w_q_d   = 2'd0;
         w_bit_d = 3'd7;
         w_ack_d = 1'b0;
         if (iic_trig) begin
            w_state_d   = StStart;
            w_dev_d     = device_id[7:1];
            w_wr_d      = w_r;
            w_addr_d    = addr;
            w_wdata_d   = data_in;
            w_ack_err_d = 1'b0;
            w_shift_d   = {device_id[7:1], W_BIT};
         end
      end else if (w_tick) begin
         w_q_d = r_q + 2'd1;
         if (r_q == 2'd2) begin
            // Sample point: SCL has been high for two quarters.
            if (r_ack) begin
               if (r_state == StRdata) begin
                  w_data_out_d  = r_shift;
                  w_byte_over_d = 1'b1;
               end else if (w_tx_state) begin
                  if (sda_in) begin
                     w_ack_err_d = 1'b1;
                  end else if (r_state == StWdata) begin
                     w_byte_over_d = 1'b1;
                  end
               end
            end else if (r_state == StRdata) begin
               w_shift_d = {r_shift[6:0], sda_in};
            end
         end else if (r_q == 2'd3) begin
            case (r_state)
               StStart: w_state_d = StDevW;
               StRstart: begin
                  w_state_d = StDevR;
                  w_shift_d = {r_dev, R_BIT};
               end
               StStop: w_state_d = StIdle;
               default: begin
                  if (!r_ack) begin
                     if (r_bit == 3'd0) begin
                        w_ack_d = 1'b1;
                     end else begin
                        w_bit_d = r_bit - 3'd1;
                     end
                     if (r_state != StRdata) begin
                        w_shift_d = {r_shift[6:0], 1'b0};
                     end
                  end else begin
                     w_ack_d = 1'b0;
                     w_bit_d = 3'd7;
                     if (r_ack_err) begin
                        w_state_d = StStop;
                     end else begin
                        case (r_state)
                           StDevW: begin
                              w_state_d = StAddrH;
                              w_shift_d = r_addr[15:8];
                           end
                           StAddrH: begin
                              w_state_d = StAddrL;
                              w_shift_d = r_addr[7:0];
                           end
                           StAddrL: begin
                              if (r_wr) begin
                                 w_state_d = StWdata;
                                 w_shift_d = r_wdata;
                              end else begin
                                 w_state_d = StRstart;
                              end
                           end
                           StDevR:  w_state_d = StRdata;
                           default: w_state_d = StStop;
                        endcase
                     end
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= StIdle;
         r_q         <= 2'd0;
         r_bit       <= 3'd7;
         r_ack       <= 1'b0;
         r_shift     <= 8'h00;
         r_dev       <= 7'h00;
         r_wr        <= 1'b0;
         r_addr      <= 16'h0000;
         r_wdata     <= 8'h00;
         r_data_out  <= 8'h00;
         r_ack_err   <= 1'b0;
         r_byte_over <= 1'b0;
         r_busy      <= 1'b0;
         r_scl       <= 1'b1;
         r_sda_oe    <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_q         <= w_q_d;
         r_bit       <= w_bit_d;
         r_ack       <= w_ack_d;
         r_shift     <= w_shift_d;
         r_dev       <= w_dev_d;
         r_wr        <= w_wr_d;
         r_addr      <= w_addr_d;
         r_wdata     <= w_wdata_d;
         r_data_out  <= w_data_out_d;
         r_ack_err   <= w_ack_err_d;
         r_byte_over <= w_byte_over_d;
         r_busy      <= (w_state_d != StIdle);
         r_scl       <= w_drive[1];
         r_sda_oe    <= w_drive[0];
      end
   end

   assign busy      = r_busy;
   assign data_out  = r_data_out;
   assign byte_over = r_byte_over;
   assign ack_err   = r_ack_err;
   assign scl       = r_scl;
   assign sda_oe    = r_sda_oe;

endmodule

// File: tb/tb_iic_master_a16d8.sv
// Directed bench for iic_master_a16d8 with a behavioural I2C slave and bus event log.
module tb_iic_master_a16d8;

   localparam logic [9:0] S_EV  = 10'h100;
   localparam logic [9:0] SR_EV = 10'h101;
   localparam logic [9:0] P_EV  = 10'h102;
   localparam logic [9:0] NK    = 10'h200;

   logic        clk, rstn, iic_trig, w_r, sda_in;
   logic [7:0]  device_id, data_in, data_out;
   logic [15:0] addr;
   logic        busy, byte_over, ack_err, scl, sda_oe;

   logic        slv_pull;
   logic        scl_p, sda_p, s, in_txn, rd_mode, ackb;
   logic [7:0]  sh, rd_byte, bo_data;
   int          bitn, bidx, gidx, nack_at, hi_cnt, min_s_hi, bo_cnt, bo0, cyc;
   int          n_chk, n_pass;
   logic [9:0]  log_q[$];
   logic [9:0]  exp_q[$];

   assign sda_in = ~sda_oe & ~slv_pull;

   iic_master_a16d8 #(
      .CLK_FREQ (1_600_000),
      .IIC_FREQ (100_000)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .device_id (device_id),
      .iic_trig  (iic_trig),
      .w_r       (w_r),
      .addr      (addr),
      .data_in   (data_in),
      .busy      (busy),
      .data_out  (data_out),
      .byte_over (byte_over),
      .ack_err   (ack_err),
      .scl       (scl),
      .sda_oe    (sda_oe),
      .sda_in    (sda_in)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Slave model and bus event logger.
   initial begin
      slv_pull = 1'b0; scl_p = 1'b1; sda_p = 1'b1; in_txn = 1'b0; rd_mode = 1'b0;
      ackb = 1'b0; sh = 8'h00; bitn = 0; bidx = 0; gidx = 0; hi_cnt = 0;
      forever begin
         @(posedge clk); #1;
         s = ~sda_oe & ~slv_pull;
         if (!rstn) begin
            bitn = 0; in_txn = 1'b0; rd_mode = 1'b0; slv_pull = 1'b0;
         end else if (scl && scl_p && sda_p && !s) begin
            log_q.push_back(in_txn ? SR_EV : S_EV);
            if (!in_txn) begin
               gidx = 0;
               if (hi_cnt < min_s_hi) min_s_hi = hi_cnt;
            end
            in_txn = 1'b1; bitn = 0; bidx = 0; rd_mode = 1'b0; slv_pull = 1'b0;
         end else if (scl && scl_p && !sda_p && s) begin
            log_q.push_back(P_EV);
            in_txn = 1'b0; bitn = 0; slv_pull = 1'b0;
         end else if (in_txn && scl && !scl_p) begin
            if (bitn < 8) begin
               sh = {sh[6:0], s};
            end else begin
               ackb = s;
               log_q.push_back({s, 1'b0, sh});
            end
            bitn++;
         end else if (in_txn && !scl && scl_p) begin
            if (bitn == 8) begin
               slv_pull = !rd_mode && (gidx != nack_at);
            end else if (bitn == 9) begin
               rd_mode = (bidx == 0) && sh[0] && !ackb;
               bitn = 0; bidx++; gidx++;
               slv_pull = rd_mode && !rd_byte[7];
            end else begin
               slv_pull = rd_mode && !rd_byte[7-bitn];
            end
         end
         hi_cnt = (scl && s) ? hi_cnt + 1 : 0;
         scl_p = scl;
         sda_p = s;
      end
   end

   initial begin
      bo_cnt = 0; bo_data = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (byte_over) begin
            bo_cnt++;
            bo_data = data_out;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic chk_log(input string tag);
      chk({tag, "_len"}, log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < log_q.size()) chk($sformatf("%s_%0d", tag, i), {22'd0, log_q[i]},
                                   {22'd0, exp_q[i]});
      end
      log_q.delete();
      exp_q.delete();
   endtask

   task automatic exp_write(input logic [9:0] ah, input logic [9:0] al, input logic [9:0] d);
      exp_q.push_back(S_EV); exp_q.push_back(10'h0B2); exp_q.push_back(ah);
      exp_q.push_back(al); exp_q.push_back(d); exp_q.push_back(P_EV);
   endtask

   task automatic trig(input logic [7:0] dev, input logic wr, input logic [15:0] a,
                       input logic [7:0] d);
      device_id = dev; w_r = wr; addr = a; data_in = d; iic_trig = 1'b1;
      @(negedge clk);
      iic_trig = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("idle_reached", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      n_chk = 0; n_pass = 0; nack_at = -1; rd_byte = 8'h5A; min_s_hi = 1000;
      rstn = 1'b0; iic_trig = 1'b0; w_r = 1'b1; device_id = 8'h00; addr = 16'h0; data_in = 8'h0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_data_out", {24'd0, data_out}, 32'h00);
      chk("rst_byte_over", {31'd0, byte_over}, 32'd0);
      chk("rst_ack_err", {31'd0, ack_err}, 32'd0);
      chk("rst_scl", {31'd0, scl}, 32'd1);
      chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
      rstn = 1'b1;
      repeat (3) @(negedge clk);

      // Write 0x04 to 0x1281: 38 bits of 16 clocks = 608 busy cycles.
      bo0 = bo_cnt;
      trig(8'hB2, 1'b1, 16'h1281, 8'h04);
      chk("wr_busy_rise", {31'd0, busy}, 32'd1);
      wait_idle(cyc);
      chk("wr_busy_len", {31'd0, (cyc >= 606 && cyc <= 610)}, 32'd1);
      chk("wr_byte_over", bo_cnt - bo0, 32'd1);
      chk("wr_ack_err", {31'd0, ack_err}, 32'd0);
      exp_write(10'h012, 10'h081, 10'h004);
      chk_log("wr_log");

      // Read 0x0003, slave returns 0x5A: 48 bits = 768 busy cycles.
      bo0 = bo_cnt;
      trig(8'hB2, 1'b0, 16'h0003, 8'hEE);
      wait_idle(cyc);
      chk("rd_busy_len", {31'd0, (cyc >= 766 && cyc <= 770)}, 32'd1);
      chk("rd_byte_over", bo_cnt - bo0, 32'd1);
      chk("rd_data_at_pulse", {24'd0, bo_data}, 32'h5A);
      chk("rd_data_out", {24'd0, data_out}, 32'h5A);
      chk("rd_ack_err", {31'd0, ack_err}, 32'd0);
      exp_q.push_back(S_EV); exp_q.push_back(10'h0B2); exp_q.push_back(10'h000);
      exp_q.push_back(10'h003); exp_q.push_back(SR_EV); exp_q.push_back(10'h0B3);
      exp_q.push_back(NK | 10'h05A); exp_q.push_back(P_EV);
      chk_log("rd_log");

      // Slave NACKs the low address byte.
      nack_at = 2;
      bo0 = bo_cnt;
      trig(8'hB2, 1'b1, 16'h1281, 8'h77);
      wait_idle(cyc);
      chk("nk_ack_err", {31'd0, ack_err}, 32'd1);
      chk("nk_byte_over", bo_cnt - bo0, 32'd0);
      chk("nk_data_out", {24'd0, data_out}, 32'h5A);
      exp_q.push_back(S_EV); exp_q.push_back(10'h0B2); exp_q.push_back(10'h012);
      exp_q.push_back(NK | 10'h081); exp_q.push_back(P_EV);
      chk_log("nk_log");
      nack_at = -1;

      // New trigger clears ack_err; a trigger during ADDRH is ignored.
      bo0 = bo_cnt;
      trig(8'hB2, 1'b1, 16'h1281, 8'h04);
      chk("clr_ack_err", {31'd0, ack_err}, 32'd0);
      repeat (180) @(negedge clk);
      trig(8'hB2, 1'b1, 16'hAAAA, 8'h55);
      wait_idle(cyc);
      repeat (300) @(negedge clk);
      chk("tb_busy_after", {31'd0, busy}, 32'd0);
      chk("tb_byte_over", bo_cnt - bo0, 32'd1);
      exp_write(10'h012, 10'h081, 10'h004);
      chk_log("tb_log");

      // Three back-to-back writes, re-triggered in the first idle cycle.
      bo0 = bo_cnt;
      min_s_hi = 1000;
      trig(8'hB2, 1'b1, 16'h1281, 8'h10);
      wait_idle(cyc);
      trig(8'hB2, 1'b1, 16'h1281, 8'h20);
      chk("b2b_accept", {31'd0, busy}, 32'd1);
      wait_idle(cyc);
      trig(8'hB2, 1'b1, 16'h1281, 8'h30);
      wait_idle(cyc);
      chk("b2b_byte_over", bo_cnt - bo0, 32'd3);
      chk("b2b_bus_free", {31'd0, (min_s_hi >= 4)}, 32'd1);
      exp_write(10'h012, 10'h081, 10'h010);
      exp_write(10'h012, 10'h081, 10'h020);
      exp_write(10'h012, 10'h081, 10'h030);
      chk_log("b2b_log");

      // Reset asserted during the data byte of a write.
      bo0 = bo_cnt;
      trig(8'hB2, 1'b1, 16'h1281, 8'hC3);
      repeat (503) @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("mid_rst_scl", {31'd0, scl}, 32'd1);
      chk("mid_rst_sda_oe", {31'd0, sda_oe}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_byte_over", bo_cnt - bo0, 32'd0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      log_q.delete();
      bo0 = bo_cnt;
      trig(8'hB2, 1'b1, 16'h1281, 8'h04);
      wait_idle(cyc);
      chk("post_rst_byte_over", bo_cnt - bo0, 32'd1);
      chk("post_rst_ack_err", {31'd0, ack_err}, 32'd0);
      exp_write(10'h012, 10'h081, 10'h004);
      chk_log("post_rst_log");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
